// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the cache miss handler: state encoding, the
// word-alignment mask and the memory timeout counter width.
package cache_miss_handler_pkg;

    // Control state encoding (3 bits, 6 states), kept as plain constants
    // so older tooling and waveform filters keep working.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOOKUP = 3'd1;
    localparam state_t ST_RD_MEM = 3'd2;
    localparam state_t ST_FILL   = 3'd3;
    localparam state_t ST_WR_MEM = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // Clears the byte offset of a word address; sliced to the address width
    // at the point of use.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

    // Width of the memory wait counter; bounds MEM_TIMEOUT to 65535.
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating 32-bit event counter used by the optional performance
// statistics of the cache miss handler.
module cache_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: sequences CPU data accesses through a direct-mapped
// cache (lookup, miss fetch, refill) and write-through to memory, stalling
// the CPU until each access completes and flagging memory timeouts.
// Optional macro CACHE_PERF_COUNTERS_EN adds hit/miss/timeout counters.
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_err,
    input  logic                  cache_hit,
    input  logic                  cache_miss,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           timeout_count
`endif
);

    // Last counter value before a wait is abandoned.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(MEM_TIMEOUT - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_aligned;
    // Holds the CPU write data for a write, or the fetched word for a miss.
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;
    logic [TMO_CNT_W-1:0]   tmo_cnt_q;
    logic                   mem_busy;
    logic                   timeout;

    assign addr_aligned = addr_q & WORD_ALIGN_MASK[ADDR_WIDTH-1:0];
    assign mem_busy     = (state_q == ST_RD_MEM) || (state_q == ST_WR_MEM);
    // A ready in the limit cycle completes the access rather than timing out.
    assign timeout      = mem_busy && !mem_ready && (tmo_cnt_q == TMO_LAST);

    // Next-state selection for the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_write) begin
                    state_d = ST_WR_MEM;
                end else if (cpu_read) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cache_hit) begin
                    state_d = ST_DONE;
                end else if (cache_miss) begin
                    state_d = ST_RD_MEM;
                end
            end
            ST_RD_MEM: begin
                if (mem_ready) begin
                    state_d = ST_FILL;
                end else if (timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_FILL:   state_d = ST_DONE;
            ST_WR_MEM: begin
                if (mem_ready || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register plus address/data latches, read result and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_write) begin
                        addr_q <= cpu_addr;
                        data_q <= cpu_wdata;
                    end else if (cpu_read) begin
                        addr_q <= cpu_addr;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        rdata_q <= cache_rdata;
                    end
                end
                ST_RD_MEM: begin
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ST_FILL: rdata_q <= data_q;
                ST_WR_MEM: begin
                    if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                ST_DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Memory wait counter: idles at zero, counts non-ready cycles while a
    // memory request is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (!mem_busy) begin
            tmo_cnt_q <= '0;
        end else if (!mem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_stall = (state_q == ST_IDLE) ? (cpu_read || cpu_write)
                                            : (state_q != ST_DONE);
    assign cpu_err   = (state_q == ST_DONE) && err_q;

    assign fill_en   = (state_q == ST_FILL);
    assign fill_addr = addr_aligned;
    assign fill_data = data_q;

    assign mem_req   = mem_busy;
    assign mem_we    = (state_q == ST_WR_MEM);
    assign mem_addr  = addr_aligned;
    assign mem_wdata = data_q;

`ifdef CACHE_PERF_COUNTERS_EN
    // A lookup reporting both hit and miss is treated as a hit, matching
    // the sequencer.
    cache_perf_counter u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == ST_LOOKUP) && cache_hit),
        .count (hit_count)
    );

    cache_perf_counter u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == ST_LOOKUP) && cache_miss && !cache_hit),
        .count (miss_count)
    );

    cache_perf_counter u_tmo_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (timeout),
        .count (timeout_count)
    );
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler with MEM_TIMEOUT=8.
module tb_cache_miss_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        cache_hit = 1'b0;
    logic        cache_miss = 1'b0;
    logic [31:0] cache_rdata = '0;
    logic        fill_en;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] timeout_count;
`endif

    int checks = 0;
    int failures = 0;

    // Observations from the last access
    int          n_req;
    int          n_fill;
    int          we_cnt;
    int          first_req_cyc;
    logic        first_req_we;
    int          done_cyc;
    logic [31:0] saw_addr;
    logic [31:0] saw_wdata;
    logic [31:0] fill_d;
    logic [31:0] fill_a;
    logic [31:0] got_rdata;
    logic        got_err;

    cache_miss_handler #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .cpu_err     (cpu_err),
        .cache_hit   (cache_hit),
        .cache_miss  (cache_miss),
        .cache_rdata (cache_rdata),
        .fill_en     (fill_en),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .timeout_count (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request in IDLE and play cache/memory until DONE.
    // lk: 1 = cache hit, 2 = cache miss. wait_n: memory-ready cycle (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int lk, input logic [31:0] cd,
                             input int wait_n, input logic [31:0] md);
        int  cyc;
        int  req_run;
        bit  done;
        n_req = 0; n_fill = 0; we_cnt = 0; first_req_cyc = 0; first_req_we = 1'b0;
        done_cyc = 0; saw_addr = '0; saw_wdata = '0; fill_d = '0; fill_a = '0;
        got_rdata = '0; got_err = 1'b0;
        req_run = 0; done = 1'b0; cyc = 1;
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            cyc++;
            cache_hit = 1'b0; cache_miss = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
            if (cyc == 2 && rd && !wr) begin
                cache_hit = (lk == 1); cache_miss = (lk == 2); cache_rdata = cd;
            end
            if (mem_req) begin
                n_req++; req_run++;
                if (first_req_cyc == 0) begin
                    first_req_cyc = cyc; first_req_we = mem_we;
                end
                if (mem_we) we_cnt++;
                saw_addr = mem_addr; saw_wdata = mem_wdata;
                mem_ready = (wait_n > 0) && (req_run == wait_n);
                mem_rdata = md;
            end
            if (fill_en) begin
                n_fill++; fill_d = fill_data; fill_a = fill_addr;
            end
            if (!cpu_stall) begin
                done = 1'b1; done_cyc = cyc; got_rdata = cpu_rdata; got_err = cpu_err;
                cpu_read = 1'b0; cpu_write = 1'b0;
            end
        end
        if (!done) check_val("access_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (fill_en) n_fill++;
        check_val("idle_after_done_stall", 32'(cpu_stall), 32'd0);
    endtask

    initial begin
        int fills;
        int reqs;

        // Reset state
        #12;
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_stall", 32'(cpu_stall), 32'd0);
        check_val("rst_fill_en", 32'(fill_en), 32'd0);
        check_val("rst_rdata", cpu_rdata, 32'd0);
        check_val("rst_err", 32'(cpu_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Read hit
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
        check_val("hit_done_cyc", 32'(done_cyc), 32'd3);
        check_val("hit_rdata", got_rdata, 32'hDEADBEEF);
        check_val("hit_mem_req", 32'(n_req), 32'd0);
        check_val("hit_fill", 32'(n_fill), 32'd0);
        check_val("hit_err", 32'(got_err), 32'd0);

        // Read miss, memory ready on the 4th request cycle
        do_access(1'b1, 1'b0, 32'h1237, 32'h0, 2, 32'h0, 4, 32'hCAFEF00D);
        check_val("miss_done_cyc", 32'(done_cyc), 32'd8);
        check_val("miss_req_cycles", 32'(n_req), 32'd4);
        check_val("miss_mem_addr", saw_addr, 32'h1234);
        check_val("miss_mem_we", 32'(we_cnt), 32'd0);
        check_val("miss_fill_pulses", 32'(n_fill), 32'd1);
        check_val("miss_fill_data", fill_d, 32'hCAFEF00D);
        check_val("miss_fill_addr", fill_a, 32'h1234);
        check_val("miss_rdata", got_rdata, 32'hCAFEF00D);
        check_val("miss_err", 32'(got_err), 32'd0);

        // Write-through, ready on the 2nd request cycle
        do_access(1'b0, 1'b1, 32'h80, 32'h11223344, 0, 32'h0, 2, 32'h0);
        check_val("wr_done_cyc", 32'(done_cyc), 32'd4);
        check_val("wr_req_cycles", 32'(n_req), 32'd2);
        check_val("wr_mem_we", 32'(we_cnt), 32'd2);
        check_val("wr_mem_addr", saw_addr, 32'h80);
        check_val("wr_mem_wdata", saw_wdata, 32'h11223344);
        check_val("wr_fill", 32'(n_fill), 32'd0);
        check_val("wr_err", 32'(got_err), 32'd0);
        check_val("wr_rdata_kept", got_rdata, 32'hCAFEF00D);

        // Simultaneous read and write: write wins, memory write starts next cycle
        do_access(1'b1, 1'b1, 32'h102, 32'h55AA55AA, 0, 32'h0, 1, 32'h0);
        check_val("both_first_req_cyc", 32'(first_req_cyc), 32'd2);
        check_val("both_first_we", 32'(first_req_we), 32'd1);
        check_val("both_mem_addr", saw_addr, 32'h100);
        check_val("both_done_cyc", 32'(done_cyc), 32'd3);

        // Read miss that times out
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 2, 32'h0, 0, 32'h0);
        check_val("rto_req_cycles", 32'(n_req), 32'd8);
        check_val("rto_done_cyc", 32'(done_cyc), 32'd11);
        check_val("rto_err", 32'(got_err), 32'd1);
        check_val("rto_rdata", got_rdata, 32'd0);
        check_val("rto_fill", 32'(n_fill), 32'd0);

        // Ready on the limit cycle completes normally
        do_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h0, 8, 32'h0BADF00D);
        check_val("rlim_req_cycles", 32'(n_req), 32'd8);
        check_val("rlim_done_cyc", 32'(done_cyc), 32'd12);
        check_val("rlim_err", 32'(got_err), 32'd0);
        check_val("rlim_rdata", got_rdata, 32'h0BADF00D);
        check_val("rlim_fill", 32'(n_fill), 32'd1);

        // Write that times out
        do_access(1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 0, 32'h0, 0, 32'h0);
        check_val("wto_req_cycles", 32'(n_req), 32'd8);
        check_val("wto_done_cyc", 32'(done_cyc), 32'd10);
        check_val("wto_err", 32'(got_err), 32'd1);
        check_val("wto_rdata_kept", got_rdata, 32'h0BADF00D);

`ifdef CACHE_PERF_COUNTERS_EN
        check_val("perf_hits", hit_count, 32'd1);
        check_val("perf_misses", miss_count, 32'd3);
        check_val("perf_timeouts", timeout_count, 32'd2);
`endif

        // Reset while waiting on memory
        cpu_read = 1'b1; cpu_addr = 32'h400;
        @(posedge clk); #1;
        cache_miss = 1'b1;
        @(posedge clk); #1;
        cache_miss = 1'b0;
        check_val("rst_mid_pre_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0; cpu_read = 1'b0;
        #1;
        check_val("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mid_stall", 32'(cpu_stall), 32'd0);
        check_val("rst_mid_fill", 32'(fill_en), 32'd0);
        check_val("rst_mid_rdata", cpu_rdata, 32'd0);
        check_val("rst_mid_err", 32'(cpu_err), 32'd0);
`ifdef CACHE_PERF_COUNTERS_EN
        check_val("rst_perf_hits", hit_count, 32'd0);
        check_val("rst_perf_misses", miss_count, 32'd0);
        check_val("rst_perf_timeouts", timeout_count, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        fills = 0; reqs = 0;
        mem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (fill_en) fills++;
            if (mem_req) reqs++;
        end
        mem_ready = 1'b0;
        check_val("rst_after_fill", 32'(fills), 32'd0);
        check_val("rst_after_req", 32'(reqs), 32'd0);
        check_val("rst_after_err", 32'(cpu_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Control stage sitting between the CPU data port, the direct-mapped data cache and backing data memory.
- Sequences each CPU access:
  - Reads: cache lookup; on a miss, a memory fetch followed by a cache fill.
  - Writes: write-through to memory.
- Stalls the CPU until the access completes and flags memory timeouts.

Parameters:
- ADDR_WIDTH, 32, CPU/memory byte-address width.
- DATA_WIDTH, 32, word width.
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting (1..65535).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cpu_read  input  1  CPU read request, held until cpu_stall low.
- cpu_write  input  1  CPU write request, held until cpu_stall low.
- cpu_addr  input  ADDR_WIDTH  CPU byte address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_rdata  output  DATA_WIDTH  read result, valid when cpu_stall low in DONE.
- cpu_stall  output  1  CPU must hold request while high.
- cpu_err  output  1  one-cycle pulse in DONE when the access timed out.
- cache_hit  input  1  registered hit from cache, one cycle after lookup.
- cache_miss  input  1  registered miss from cache, one cycle after lookup.
- cache_rdata  input  DATA_WIDTH  cache read data, valid with cache_hit.
- fill_en  output  1  one-cycle cache write strobe for refill.
- fill_addr  output  ADDR_WIDTH  word-aligned refill address.
- fill_data  output  DATA_WIDTH  refill data.
- mem_req  output  1  memory request, held until mem_ready.
- mem_we  output  1  1 = write, 0 = read; stable while mem_req high.
- mem_addr  output  ADDR_WIDTH  word-aligned, low 2 bits forced 0.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_ready  input  1  memory completion; for reads, mem_rdata valid same cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all registered outputs, address/data latches and the timeout counter clear to 0.
  - Reset mid-transaction abandons it with no fill and no error pulse.
- States: IDLE, LOOKUP, RD_MEM, FILL, WR_MEM, DONE.
- IDLE:
  - cpu_write=1: latch addr/wdata, go to WR_MEM. Write has priority if both requests are high.
  - Else cpu_read=1: latch addr, go to LOOKUP.
  - cpu_stall is combinational: high in IDLE when cpu_read or cpu_write is high.
- LOOKUP:
  - cache_hit: cpu_rdata<=cache_rdata, go to DONE.
  - cache_miss: go to RD_MEM.
  - Neither: remain in LOOKUP.
- RD_MEM:
  - mem_req=1, mem_we=0, mem_addr={latched_addr[ADDR_WIDTH-1:2],2'b00}.
  - On mem_ready: latch mem_rdata, go to FILL.
  - On timeout: cpu_rdata<=0, set err flag, go to DONE.
- FILL:
  - fill_en=1 for exactly one cycle, with fill_addr=word-aligned latched addr and fill_data=latched data.
  - cpu_rdata<=latched data; go to DONE.
- WR_MEM:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata.
  - On mem_ready: go to DONE. The cache is updated by its own memwrite path, not by this block.
  - On timeout: set err flag, go to DONE.
- DONE:
  - cpu_stall=0 for one cycle; cpu_err=err flag; then clear err and go to IDLE unconditionally.
  - Requests present in DONE are not accepted; the CPU re-presents the next request in the following cycle.
- Timeout counter:
  - Cleared on entry to RD_MEM/WR_MEM; increments each cycle mem_ready=0.
  - Timeout fires when the count equals MEM_TIMEOUT-1 with mem_ready=0.
  - If mem_ready=1 in the same cycle the count reaches the limit, completion wins.
- Latency:
  - Read hit: 3 cycles request-to-DONE (IDLE, LOOKUP, DONE).
  - Read miss: 4 + memory wait cycles.
  - Write: 2 + memory wait cycles.
- mem_req deasserts the cycle after mem_ready; it is never re-asserted without returning through IDLE.

Optional Feature:
- Macro: CACHE_PERF_COUNTERS_EN.
- When defined, adds outputs hit_count[31:0], miss_count[31:0], timeout_count[31:0]:
  - hit_count increments on LOOKUP with cache_hit.
  - miss_count increments on LOOKUP with cache_miss.
  - timeout_count increments on each timeout.
  - All saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - The state encoding enum (6 states, 3 bits).
  - The word-alignment mask constant.
  - The timeout counter width, 16 bits.
- One natural sub-module, cache_perf_counter: a saturating 32-bit counter with inc and reset, instantiated three times only under CACHE_PERF_COUNTERS_EN.

Test Plan:
- Read hit: cpu_read, addr 0x40, cache_hit with cache_rdata 0xDEADBEEF one cycle later -> stall low on the 3rd cycle, cpu_rdata=0xDEADBEEF, mem_req never high.
- Read miss: addr 0x1237, cache_miss, mem_ready after 4 cycles with 0xCAFEF00D -> mem_addr=0x1234, mem_we=0, one fill_en pulse with fill_data=0xCAFEF00D, then DONE with cpu_rdata=0xCAFEF00D.
- Write-through: cpu_write, addr 0x80, data 0x11223344, mem_ready after 2 cycles -> mem_we=1, mem_wdata=0x11223344, no fill_en, cpu_err=0.
- Simultaneous cpu_read and cpu_write -> WR_MEM taken, LOOKUP never entered.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_req high for exactly 8 cycles, DONE with cpu_err=1, cpu_rdata=0; a second case with mem_ready on the 8th cycle completes normally with cpu_err=0.
- Reset asserted while in RD_MEM -> mem_req and cpu_stall drop immediately, state IDLE, no fill_en; with CACHE_PERF_COUNTERS_EN, counters read 0.
